animation_select: RTL and testbench

Upstream control stage for the seven-segment animation display. Replaces the hard-wired animation switches with two debounced pushbuttons, next and prev, plus a direct-load port. It holds the current animation index (0–5) and drives three values into the display counter/decoder stage: the index, the per-animation digit limit, and a one-cycle change pulse that the downstream stage uses to restart its digit count.

---
 rtl/animation_select.sv | 111 +++++++++++
 tb/tb_animation_select.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/animation_select.sv
// Animation index selector: debounced next/prev pushbuttons plus a direct-load port,
// driving the animation index, its digit limit and a one-cycle change pulse downstream.
module animation_select #(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       sel_load,
  input  logic [2:0] sel_value,
  output logic [2:0] animation,
  output logic [3:0] limit,
  output logic       ani_changed
);

  typedef enum logic [2:0] {
    ANI0 = 3'd0,
    ANI1 = 3'd1,
    ANI2 = 3'd2,
    ANI3 = 3'd3,
    ANI4 = 3'd4,
    ANI5 = 3'd5
  } ani_state_t;

  // Index 0 is the next button, index 1 the prev button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       db_q, db_d;
  logic [1:0][23:0] cnt_q, cnt_d;
  logic [1:0]       press;

  ani_state_t state_q, state_d;
  logic [3:0] limit_q, limit_d;
  logic       ani_changed_q, ani_changed_d;

  assign btn_raw = {btn_prev, btn_next};

  // A press is flagged in the cycle the debouncer accepts a rising level, so the
  // state register moves on the same edge at which the debounced level goes high.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    press   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = 24'd0;
      end else if (cnt_q[i] == DEBOUNCE_CYCLES - 24'd1) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = 24'd0;
        press[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 24'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      if (sel_load) begin
        if (sel_value <= 3'd5) begin
          state_d = ani_state_t'(sel_value);
        end
      end else begin
        case (press)
          2'b01:   state_d = (state_q == ANI5) ? ANI0 : ani_state_t'(state_q + 3'd1);
          2'b10:   state_d = (state_q == ANI0) ? ANI5 : ani_state_t'(state_q - 3'd1);
          default: state_d = state_q;
        endcase
      end
    end

    ani_changed_d = (state_d != state_q);

    case (state_d)
      ANI0:             limit_d = 4'd9;
      ANI1, ANI2, ANI3: limit_d = 4'd6;
      default:          limit_d = 4'd5;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= 2'b00;
      sync2_q       <= 2'b00;
      db_q          <= 2'b00;
      cnt_q         <= '0;
      state_q       <= ANI0;
      limit_q       <= 4'd9;
      ani_changed_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_q          <= db_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      limit_q       <= limit_d;
      ani_changed_q <= ani_changed_d;
    end
  end

  assign animation   = state_q;
  assign limit       = limit_q;
  assign ani_changed = ani_changed_q;

endmodule

// File: tb/tb_animation_select.sv
// Directed testbench for animation_select with a 4-cycle debounce window.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_animation_select;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       btn_next;
  logic       btn_prev;
  logic       sel_load;
  logic [2:0] sel_value;
  logic [2:0] animation;
  logic [3:0] limit;
  logic       ani_changed;

  int tests_run;
  int tests_failed;

  animation_select #(
    .DEBOUNCE_CYCLES(24'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .sel_load   (sel_load),
    .sel_value  (sel_value),
    .animation  (animation),
    .limit      (limit),
    .ani_changed(ani_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (animation !== 3'd0 || limit !== 4'd9 || ani_changed !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold cycle %0d: got ani=%0d lim=%0d chg=%0b expected ani=0 lim=9 chg=0",
                 c, animation, limit, ani_changed);
      end
    end
  endtask

  // Button set before edge k: outputs change after edge k+5, i.e. on the 6th step.
  task automatic test_next_wrap();
    logic [2:0] exp_ani [6];
    logic [3:0] exp_lim [6];
    logic [2:0] prev_ani;
    int pulses;
    exp_ani = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_lim = '{4'd6, 4'd6, 4'd6, 4'd5, 4'd5, 4'd9};
    prev_ani = 3'd0;
    for (int p = 0; p < 6; p++) begin
      pulses = 0;
      btn_next = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        step();
        if (ani_changed === 1'b1) pulses++;
        if (c == 5) begin
          tests_run++;
          if (animation !== prev_ani || ani_changed !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL next_early press %0d: got ani=%0d chg=%0b expected ani=%0d chg=0",
                     p, animation, ani_changed, prev_ani);
          end
        end
        if (c == 6) begin
          tests_run++;
          if (animation !== exp_ani[p] || limit !== exp_lim[p] || ani_changed !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL next_step press %0d: got ani=%0d lim=%0d chg=%0b expected ani=%0d lim=%0d chg=1",
                     p, animation, limit, ani_changed, exp_ani[p], exp_lim[p]);
          end
        end
      end
      btn_next = 1'b0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (ani_changed === 1'b1) pulses++;
      end
      tests_run++;
      if (pulses != 1 || animation !== exp_ani[p]) begin
        tests_failed++;
        $display("[TB] FAIL next_pulse_count press %0d: got pulses=%0d ani=%0d expected pulses=1 ani=%0d",
                 p, pulses, animation, exp_ani[p]);
      end
      prev_ani = exp_ani[p];
    end
  endtask

  task automatic test_bounce();
    logic [0:10] pat;
    int pulses;
    int pulse_at;
    pat = 11'b11101101111;
    pulses = 0;
    pulse_at = -1;
    for (int n = 0; n < 30; n++) begin
      btn_next = (n < 11) ? pat[n] : 1'b1;
      step();
      if (ani_changed === 1'b1) begin
        pulses++;
        pulse_at = n;
      end
    end
    tests_run++;
    if (pulses != 1 || pulse_at != 12) begin
      tests_failed++;
      $display("[TB] FAIL bounce_timing: got pulses=%0d at_step=%0d expected pulses=1 at_step=12",
               pulses, pulse_at);
    end
    tests_run++;
    if (animation !== 3'd1 || limit !== 4'd6) begin
      tests_failed++;
      $display("[TB] FAIL bounce_result: got ani=%0d lim=%0d expected ani=1 lim=6", animation, limit);
    end
    btn_next = 1'b0;
    idle(10);
  endtask

  task automatic test_prev_simultaneous();
    int pulses;
    sel_load  = 1'b1;
    sel_value = 3'd0;
    step();
    sel_load = 1'b0;
    tests_run++;
    if (animation !== 3'd0 || limit !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL prev_setup_load0: got ani=%0d lim=%0d expected ani=0 lim=9", animation, limit);
    end
    idle(2);
    btn_prev = 1'b1;
    idle(5);
    tests_run++;
    if (animation !== 3'd0 || ani_changed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prev_early: got ani=%0d chg=%0b expected ani=0 chg=0", animation, ani_changed);
    end
    step();
    tests_run++;
    if (animation !== 3'd5 || limit !== 4'd5 || ani_changed !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL prev_wrap: got ani=%0d lim=%0d chg=%0b expected ani=5 lim=5 chg=1",
               animation, limit, ani_changed);
    end
    idle(4);
    btn_prev = 1'b0;
    idle(10);
    pulses = 0;
    btn_next = 1'b1;
    btn_prev = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ani_changed === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0 || animation !== 3'd5 || limit !== 4'd5) begin
      tests_failed++;
      $display("[TB] FAIL both_pressed: got pulses=%0d ani=%0d lim=%0d expected pulses=0 ani=5 lim=5",
               pulses, animation, limit);
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    idle(10);
  endtask

  task automatic test_direct_load();
    sel_load  = 1'b1;
    sel_value = 3'd3;
    step();
    sel_load = 1'b0;
    tests_run++;
    if (animation !== 3'd3 || limit !== 4'd6 || ani_changed !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load3: got ani=%0d lim=%0d chg=%0b expected ani=3 lim=6 chg=1",
               animation, limit, ani_changed);
    end
    step();
    tests_run++;
    if (ani_changed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load3_pulse_width: got chg=%0b expected chg=0", ani_changed);
    end
    sel_load  = 1'b1;
    sel_value = 3'd7;
    step();
    sel_load = 1'b0;
    tests_run++;
    if (animation !== 3'd3 || limit !== 4'd6 || ani_changed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load7_illegal: got ani=%0d lim=%0d chg=%0b expected ani=3 lim=6 chg=0",
               animation, limit, ani_changed);
    end
    sel_load  = 1'b1;
    sel_value = 3'd3;
    step();
    sel_load = 1'b0;
    tests_run++;
    if (animation !== 3'd3 || ani_changed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load3_same: got ani=%0d chg=%0b expected ani=3 chg=0", animation, ani_changed);
    end
    btn_next = 1'b1;
    idle(5);
    sel_load  = 1'b1;
    sel_value = 3'd4;
    step();
    sel_load = 1'b0;
    tests_run++;
    if (animation !== 3'd4 || limit !== 4'd5 || ani_changed !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load4_with_press: got ani=%0d lim=%0d chg=%0b expected ani=4 lim=5 chg=1",
               animation, limit, ani_changed);
    end
    idle(4);
    tests_run++;
    if (animation !== 3'd4 || ani_changed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL press_discarded: got ani=%0d chg=%0b expected ani=4 chg=0", animation, ani_changed);
    end
    btn_next = 1'b0;
    idle(10);
  endtask

  task automatic test_enable_reset();
    int pulses;
    pulses = 0;
    ena = 1'b0;
    btn_next = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ani_changed === 1'b1) pulses++;
    end
    btn_next = 1'b0;
    idle(10);
    ena = 1'b1;
    idle(2);
    tests_run++;
    if (pulses != 0 || animation !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL ena_low_press: got pulses=%0d ani=%0d expected pulses=0 ani=4", pulses, animation);
    end
    btn_next = 1'b1;
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    tests_run++;
    if (animation !== 3'd0 || limit !== 4'd9 || ani_changed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_values: got ani=%0d lim=%0d chg=%0b expected ani=0 lim=9 chg=0",
               animation, limit, ani_changed);
    end
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (ani_changed === 1'b1 || animation !== 3'd0) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_count_lost: got early_changes=%0d expected 0", pulses);
    end
    step();
    tests_run++;
    if (animation !== 3'd1 || limit !== 4'd6 || ani_changed !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_press: got ani=%0d lim=%0d chg=%0b expected ani=1 lim=6 chg=1",
               animation, limit, ani_changed);
    end
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (ani_changed === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0 || animation !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL hold_no_repeat: got pulses=%0d ani=%0d expected pulses=0 ani=1", pulses, animation);
    end
    btn_next = 1'b0;
    idle(5);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    btn_next  = 1'b0;
    btn_prev  = 1'b0;
    sel_load  = 1'b0;
    sel_value = 3'd0;
    step();
    test_reset();
    test_next_wrap();
    test_bounce();
    test_prev_simultaneous();
    test_direct_load();
    test_enable_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
